// File: rtl/filter_loader.sv
// filter_loader: streams filter weights (filter, channel, element order) into filter memory at c*P*RS + p*RS + e
// Ports: clk, rst (sync, active-high); start + R/S/P/Q latch a pass config; in_valid/in_data/in_ready weight stream;
// wr_en/wr_addr/wr_data filter memory write port (registered, latency 1); busy while loading; done with final write;
// cfg_err when start is rejected. Optional FILTER_LOADER_CSUM_EN adds csum, running sum of accepted words.
module filter_loader #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        R,
  input  logic [3:0]        S,
  input  logic [3:0]        P,
  input  logic [3:0]        Q,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
`ifdef FILTER_LOADER_CSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);
  typedef enum logic {IDLE, LOAD} state_t;
  state_t state_q, state_d;
  logic [7:0] fs_q, fs_d, e_q, e_d;
  logic [3:0] cip_q, cip_d, np_q, np_d, c_q, c_d, p_q, p_d;
  logic              wr_en_q, wr_en_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, addr_w;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [7:0]  fs_w;
  logic [3:0]  cip_w;
  logic [19:0] total_w;
  logic cfg_ok, go, accept, e_wrap, c_wrap, p_wrap, last;
  assign fs_w    = {4'b0, R} * {4'b0, S};
  // fs==0 is rejected anyway; forcing cip to 1 keeps the divider away from zero
  assign cip_w   = (fs_w == 8'd0 || fs_w > {4'b0, Q}) ? 4'd1 : 4'({4'b0, Q} / fs_w);
  assign total_w = 20'(P) * 20'(cip_w) * 20'(fs_w);
  assign cfg_ok  = P != 4'd0 && fs_w != 8'd0 && total_w <= 20'(DEPTH);
  assign go      = state_q == IDLE && start && cfg_ok;
  assign accept  = state_q == LOAD && in_valid;
  assign e_wrap  = e_q == fs_q - 8'd1;
  assign c_wrap  = c_q == cip_q - 4'd1;
  assign p_wrap  = p_q == np_q - 4'd1;
  assign last    = accept && e_wrap && c_wrap && p_wrap;
  // true address never exceeds DEPTH-1, so computing modulo 2^ADDR_W is exact
  assign addr_w  = ADDR_W'(c_q) * ADDR_W'(np_q) * ADDR_W'(fs_q) + ADDR_W'(p_q) * ADDR_W'(fs_q) + ADDR_W'(e_q);
  always_comb begin
    state_d   = state_q;
    fs_d      = fs_q;
    cip_d     = cip_q;
    np_d      = np_q;
    e_d       = e_q;
    c_d       = c_q;
    p_d       = p_q;
    wr_en_d   = accept;
    wr_addr_d = accept ? addr_w : wr_addr_q;
    wr_data_d = accept ? in_data : wr_data_q;
    done_d    = last;
    cfg_err_d = state_q == IDLE && start && !cfg_ok;
    if (go) begin
      state_d = LOAD;
      fs_d    = fs_w;
      cip_d   = cip_w;
      np_d    = P;
      e_d     = '0;
      c_d     = '0;
      p_d     = '0;
    end
    if (accept) begin
      e_d     = e_wrap ? '0 : e_q + 8'd1;
      c_d     = e_wrap ? (c_wrap ? '0 : c_q + 4'd1) : c_q;
      p_d     = (e_wrap && c_wrap) ? (p_wrap ? '0 : p_q + 4'd1) : p_q;
      state_d = last ? IDLE : LOAD;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fs_q      <= '0;
      cip_q     <= '0;
      np_q      <= '0;
      e_q       <= '0;
      c_q       <= '0;
      p_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fs_q      <= fs_d;
      cip_q     <= cip_d;
      np_q      <= np_d;
      e_q       <= e_d;
      c_q       <= c_d;
      p_q       <= p_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end
  assign in_ready = state_q == LOAD;
  assign busy     = state_q == LOAD;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign cfg_err  = cfg_err_q;
`ifdef FILTER_LOADER_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  assign csum_d = go ? '0 : accept ? csum_q + in_data : csum_q;
  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else csum_q <= csum_d;
  end
  assign csum = csum_q;
`endif
endmodule

// File: tb/tb_filter_loader.sv
// tb_filter_loader: table-driven, directed and randomized checks of filter_loader against an index-decomposition model
module tb_filter_loader;
  localparam int DW = 16;
  localparam int DEPTH = 1024;
  localparam int AW = 10;
  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, wr_en, busy, done, cfg_err;
  logic [3:0] R, S, P, Q;
  logic [DW-1:0] in_data, wr_data;
  logic [AW-1:0] wr_addr;
`ifdef FILTER_LOADER_CSUM_EN
  logic [DW-1:0] csum;
`endif
  logic [DW-1:0] img [0:DEPTH-1];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  filter_loader #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .R(R), .S(S), .P(P), .Q(Q),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef FILTER_LOADER_CSUM_EN
    , .csum(csum)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int cip_of(int r, int s, int q);
    int fs = r * s;
    return (fs == 0 || fs > q) ? 1 : q / fs;
  endfunction
  function automatic int total_of(int r, int s, int p, int q);
    return p * cip_of(r, s, q) * r * s;
  endfunction
  function automatic bit ok_of(int r, int s, int p, int q);
    return p != 0 && r * s != 0 && total_of(r, s, p, q) <= DEPTH;
  endfunction
  // word k of the stream is filter k/(cip*fs), channel (k/fs)%cip, element k%fs
  function automatic int addr_of(int k, int r, int s, int p, int q);
    int fs = r * s;
    int cip = cip_of(r, s, q);
    return ((k / fs) % cip) * p * fs + (k / (cip * fs)) * fs + k % fs;
  endfunction
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = 16'($urandom);
      tick;
      chk("idle_wr_en", wr_en, 0);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_cfg_err", cfg_err, 0);
    end
    in_valid = 1'b0;
  endtask
  // vmode: 0 valid held, 1 toggling, 2 random; dmode: 0 data = word index, 1 random
  task automatic do_load(input int r, input int s, input int p, input int q, input int vmode, input int dmode,
                         input int rst_after, input bit restart, output int nwr);
    int total, idx, cyc;
    bit ok, mbusy, acc;
    logic [DW-1:0] d, sum;
    R = 4'(r);
    S = 4'(s);
    P = 4'(p);
    Q = 4'(q);
    ok = ok_of(r, s, p, q);
    total = ok ? total_of(r, s, p, q) : 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_cfg_err", cfg_err, !ok);
    chk("start_busy", busy, ok);
    chk("start_wr_en", wr_en, 0);
`ifdef FILTER_LOADER_CSUM_EN
    if (ok) chk("csum_clear", csum, 0);
`endif
    R = 4'($urandom);
    S = 4'($urandom);
    P = 4'($urandom);
    Q = 4'($urandom);
    mbusy = ok;
    idx = 0;
    nwr = 0;
    cyc = 0;
    sum = '0;
    while (mbusy && cyc < 4000) begin
      in_valid = vmode == 0 ? 1'b1 : vmode == 1 ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      d = dmode == 0 ? 16'(idx) : 16'($urandom);
      in_data = d;
      start = restart && cyc == 5;
      rst = rst_after >= 0 && idx == rst_after;
      acc = in_valid && !rst;
      tick;
      start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        mbusy = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
`ifdef FILTER_LOADER_CSUM_EN
        chk("rst_csum", csum, 0);
`endif
      end else begin
        chk("wr_en", wr_en, acc);
        if (acc) begin
          chk("wr_addr", wr_addr, addr_of(idx, r, s, p, q));
          chk("wr_data", wr_data, d);
          img[wr_addr] = wr_data;
          sum = sum + d;
          idx++;
          nwr++;
        end
        mbusy = idx < total;
        chk("done", done, acc && idx == total);
        chk("load_cfg_err", cfg_err, 0);
        chk("in_ready", in_ready, mbusy);
        chk("busy", busy, mbusy);
`ifdef FILTER_LOADER_CSUM_EN
        if (!mbusy) chk("csum_done", csum, sum);
`endif
      end
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 4000) chk("load_timeout", 1, 0);
  endtask
  typedef struct {
    int r, s, p, q, vmode, dmode, exp_nwr;
  } vec_t;
  vec_t tbl [6];
  int nwr;
  initial begin
    tbl[0] = '{3, 3, 2, 9, 0, 0, 18};
    tbl[1] = '{1, 1, 3, 4, 0, 0, 12};
    tbl[2] = '{15, 15, 5, 1, 0, 1, 0};
    tbl[3] = '{3, 3, 0, 9, 0, 1, 0};
    tbl[4] = '{2, 3, 4, 5, 2, 1, 24};
    tbl[5] = '{2, 2, 8, 15, 1, 1, 96};
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    R = '0;
    S = '0;
    P = '0;
    Q = '0;
    tick;
    tick;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cfg_err", cfg_err, 0);
    rst = 1'b0;
    tick;
    for (int i = 0; i < 6; i++) begin
      do_load(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].q, tbl[i].vmode, tbl[i].dmode, -1, 1'b0, nwr);
      chk($sformatf("tbl%0d_writes", i), nwr, tbl[i].exp_nwr);
      if (i == 1) begin
        chk("c2_addr3", img[3], 1);
        chk("c2_addr1", img[1], 4);
        chk("c2_addr11", img[11], 11);
      end
      idle_check(2);
    end
    do_load(3, 3, 2, 9, 1, 0, -1, 1'b1, nwr);
    chk("toggle_restart_writes", nwr, 18);
    idle_check(2);
    do_load(3, 3, 2, 9, 0, 0, 7, 1'b0, nwr);
    chk("rst_mid_writes", nwr, 7);
    idle_check(1);
    do_load(3, 3, 2, 9, 0, 0, -1, 1'b0, nwr);
    chk("after_rst_writes", nwr, 18);
`ifdef FILTER_LOADER_CSUM_EN
    chk("csum_153", csum, 153);
`endif
    do_load(1, 1, 3, 4, 2, 1, -1, 1'b0, nwr);
    chk("b2b_writes", nwr, 12);
    idle_check(1);
    for (int i = 0; i < 20; i++) begin
      int r, s, p, q;
      r = $urandom_range(0, 4);
      s = $urandom_range(1, 5);
      p = $urandom_range(0, 9);
      q = $urandom_range(0, 15);
      do_load(r, s, p, q, 2, 1, -1, 1'b0, nwr);
      chk("rand_writes", nwr, ok_of(r, s, p, q) ? total_of(r, s, p, q) : 0);
      idle_check(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
